// File: rtl/game_pkg.sv
// game_pkg
//   Shared types and default constants for the whack-a-mole lives logic.
//   lives_state_t : IDLE / PLAY / BLINK / GAME_OVER
//   DEF_*         : default MAX_LIVES, BLINK_FRAMES and BLINK_HALF values
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    BLINK     = 2'd2,
    GAME_OVER = 2'd3
  } lives_state_t;

  localparam int DEF_MAX_LIVES    = 3;
  localparam int DEF_BLINK_FRAMES = 60;
  localparam int DEF_BLINK_HALF   = 8;

endpackage

// File: rtl/frame_blinker.sv
// frame_blinker
//   Counts frame_tick pulses across one lost-heart blink window.
//   Optional feature macro: LIVES_HEART_BLINK_EN (adds the on/off phase).
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-low reset
//   clear   in   restart the window (count 0, phase on); wins over tick
//   enable  in   window active (owner is in BLINK)
//   tick    in   one pulse per video frame
//   done    out  combinational: last frame of the window is ticking now
//   phase_d out  next value of the blink phase (only with the macro)
module frame_blinker
  import game_pkg::*;
#(
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
`ifdef LIVES_HEART_BLINK_EN
  ,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic done
`ifdef LIVES_HEART_BLINK_EN
  ,
  output logic phase_d
`endif
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    done  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

`ifdef LIVES_HEART_BLINK_EN
  // A separate modulo-BLINK_HALF counter runs in lockstep with cnt_q (both
  // cleared together), so its wrap is exactly "cnt mod BLINK_HALF == 0"
  // without needing a divider for non-power-of-two half periods.
  localparam int HW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(BLINK_HALF - 1);

  logic [HW-1:0] half_q, half_d;
  logic          phase_q;

  always_comb begin
    half_d  = half_q;
    phase_d = phase_q;
    if (clear) begin
      half_d  = '0;
      phase_d = 1'b1;
    end else if (enable && tick) begin
      if (half_q == HALF_LAST) begin
        half_d  = '0;
        phase_d = ~phase_q;
      end else begin
        half_d = half_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      half_q  <= half_d;
      phase_q <= phase_d;
    end
  end
`endif

endmodule

// File: rtl/lives_manager.sv
// lives_manager
//   Tracks remaining lives and drives one heart renderer per enable bit.
//   Optional feature macro: LIVES_HEART_BLINK_EN (lost heart blinks during
//   the invulnerability window; without it the heart clears at once).
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   start        in   pulse: begin / restart a game (highest priority)
//   miss         in   pulse: player missed a mole
//   bonus        in   pulse: award one life (saturating)
//   frame_tick   in   pulse once per video frame
//   heart_enable out  [MAX_LIVES-1:0] thermometer of lives, bit i -> heart i
//   lives        out  [2:0] current life count
//   blinking     out  high while the lost heart blinks
//   game_over    out  high in GAME_OVER
module lives_manager
  import game_pkg::*;
#(
  parameter int MAX_LIVES    = DEF_MAX_LIVES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 miss,
  input  logic                 bonus,
  input  logic                 frame_tick,
  output logic [MAX_LIVES-1:0] heart_enable,
  output logic [2:0]           lives,
  output logic                 blinking,
  output logic                 game_over
);

  localparam logic [2:0] LIVES_MAX = 3'(MAX_LIVES);

  lives_state_t         state_q, state_d;
  logic [2:0]           lives_q, lives_d;
  logic [MAX_LIVES-1:0] heart_enable_q, heart_enable_d;
  logic                 game_over_q, game_over_d;
  logic                 blink_clear;
  logic                 blink_done;
  logic [2:0]           lives_inc;

  assign lives_inc = (lives_q < LIVES_MAX) ? lives_q + 3'd1 : lives_q;

`ifdef LIVES_HEART_BLINK_EN
  logic [2:0] lost_idx_q, lost_idx_d;
  logic       phase_d;
  logic       blinking_q, blinking_d;
`endif

  frame_blinker #(
    .BLINK_FRAMES (BLINK_FRAMES)
`ifdef LIVES_HEART_BLINK_EN
    ,
    .BLINK_HALF   (BLINK_HALF)
`endif
  ) u_blinker (
    .clk     (clk),
    .reset   (reset),
    .clear   (blink_clear),
    .enable  (state_q == BLINK),
    .tick    (frame_tick),
    .done    (blink_done)
`ifdef LIVES_HEART_BLINK_EN
    ,
    .phase_d (phase_d)
`endif
  );

  // Next-state / next-lives
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    blink_clear = 1'b0;
`ifdef LIVES_HEART_BLINK_EN
    lost_idx_d  = lost_idx_q;
`endif
    if (start) begin
      state_d     = PLAY;
      lives_d     = LIVES_MAX;
      blink_clear = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          // Simultaneous miss and bonus cancel out.
          if (miss && !bonus) begin
            lives_d     = lives_q - 3'd1;
            state_d     = BLINK;
            blink_clear = 1'b1;
`ifdef LIVES_HEART_BLINK_EN
            lost_idx_d  = lives_q - 3'd1;
`endif
          end else if (bonus && !miss) begin
            lives_d = lives_inc;
          end
        end
        BLINK: begin
          // Invulnerable: miss ignored; bonus still counts.
          if (bonus) lives_d = lives_inc;
          if (blink_done) state_d = (lives_d == 3'd0) ? GAME_OVER : PLAY;
        end
        default: ;  // IDLE and GAME_OVER wait for start
      endcase
    end
  end

  // Outputs are registered from next-state values so they settle one cycle
  // after the event, together with the state.
  generate
    for (genvar gi = 0; gi < MAX_LIVES; gi++) begin : g_heart
      logic live_bit;
      assign live_bit = ((state_d == PLAY) || (state_d == BLINK)) && (3'(gi) < lives_d);
`ifdef LIVES_HEART_BLINK_EN
      assign heart_enable_d[gi] = ((state_d == BLINK) && (lost_idx_d == 3'(gi)))
                                  ? phase_d : live_bit;
`else
      assign heart_enable_d[gi] = live_bit;
`endif
    end
  endgenerate

  assign game_over_d = (state_d == GAME_OVER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      lives_q        <= 3'd0;
      heart_enable_q <= '0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      heart_enable_q <= heart_enable_d;
      game_over_q    <= game_over_d;
    end
  end

`ifdef LIVES_HEART_BLINK_EN
  assign blinking_d = (state_d == BLINK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lost_idx_q <= 3'd0;
      blinking_q <= 1'b0;
    end else begin
      lost_idx_q <= lost_idx_d;
      blinking_q <= blinking_d;
    end
  end

  assign blinking = blinking_q;
`else
  assign blinking = 1'b0;
`endif

  assign heart_enable = heart_enable_q;
  assign lives        = lives_q;
  assign game_over    = game_over_q;

endmodule

// File: doc/lives_manager.md
Name: lives_manager

Overview:
- Upstream stage of the heart display; tracks remaining player lives for whack-a-mole.
- Converts miss/bonus event pulses into a thermometer-coded per-heart enable vector that drives one heart display instance per bit.
- Blinks the just-lost heart for a fixed number of frames, then asserts game_over when no lives remain.
- Sits between the game-control FSM (event source) and the VGA heart renderers.

Parameters:
- MAX_LIVES, 3, number of hearts / maximum lives (1..7).
- BLINK_FRAMES, 60, frame_tick count for which a lost heart blinks.
- BLINK_HALF, 8, frame_ticks per blink on/off half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a game.
- miss  in  1  one-cycle pulse; player missed a mole.
- bonus  in  1  one-cycle pulse; award one life.
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived).
- heart_enable  out  MAX_LIVES  bit i drives heart i's heart_enable.
- lives  out  3  current life count.
- blinking  out  1  high while the lost-heart blink is active.
- game_over  out  1  high in GAME_OVER state.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state IDLE, lives=0, heart_enable=0, blinking=0, game_over=0, all counters 0.
- All outputs are registered. Events take effect on the clock edge after the pulse, so outputs update one cycle later.
- States: IDLE, PLAY, BLINK, GAME_OVER.
- IDLE:
  - start -> PLAY with lives=MAX_LIVES.
  - miss, bonus and frame_tick are ignored.
- PLAY:
  - miss alone: lives-1, lost_idx=new lives value, go to BLINK, blink_cnt=0, phase=on.
  - bonus alone: lives+1, saturating at MAX_LIVES.
  - miss and bonus in the same cycle: no change, stay in PLAY.
- BLINK (invulnerability window):
  - miss is ignored.
  - bonus increments lives (saturating) but does not restore the blinking heart; the lost_idx bit keeps blinking.
  - Each frame_tick increments blink_cnt. Phase toggles when blink_cnt mod BLINK_HALF wraps to 0.
  - When blink_cnt reaches BLINK_FRAMES-1 and frame_tick is high: go to GAME_OVER if lives==0, else go to PLAY.
- GAME_OVER:
  - game_over=1, heart_enable=0.
  - start -> PLAY with lives=MAX_LIVES.
- heart_enable:
  - bit i = (i < lives) in PLAY and BLINK.
  - In BLINK, bit lost_idx is additionally forced to phase.
  - All zero in IDLE and GAME_OVER.
- start in any state restarts PLAY with lives=MAX_LIVES and clears blink state. start has priority over miss and bonus in the same cycle.
- If frame_tick coincides with miss in PLAY, the BLINK entry cycle does not count a frame.
- Reset asserted mid-blink returns to IDLE immediately (asynchronous).
- Counter widths:
  - blink_cnt is $clog2(BLINK_FRAMES) bits.
  - lives is 3 bits, zero-extended.
  - No wrap below 0: miss cannot occur at lives==0 because PLAY is never held with 0 lives.

Optional Feature:
- Macro: LIVES_HEART_BLINK_EN.
- Defined:
  - BLINK behaves as above.
  - blinking is high in BLINK.
- Undefined:
  - The lost heart's bit clears immediately on miss.
  - BLINK still lasts BLINK_FRAMES as an invulnerability window, but no phase toggling occurs.
  - blinking is tied 0.
  - The phase register is not synthesised.

Decomposition:
- Shared package (game_pkg):
  - lives_state_t enum {IDLE, PLAY, BLINK, GAME_OVER}.
  - Default MAX_LIVES, BLINK_FRAMES and BLINK_HALF constants.
- Sub-module frame_blinker: counts frame_tick and produces phase plus done.
- The thermometer/enable encode remains in lives_manager.

Test Plan:
- Reset low then high, pulse start -> after 1 cycle lives=3, heart_enable=3'b111, game_over=0.
- One miss in PLAY -> lives=2; heart_enable[2] toggles every 8 frame_ticks; after 60 frame_ticks, state PLAY and heart_enable=3'b011.
- Miss during BLINK -> lives stays 2. Miss and bonus in the same PLAY cycle -> lives unchanged, no blink.
- Three misses, each after its blink completes -> after the third blink ends, game_over=1 and heart_enable=0. Subsequent miss/bonus has no effect. start -> lives=3.
- Bonus at lives=3 -> stays 3. Bonus during BLINK with lives=1 -> lives=2 while bit 1 still blinks.
- Assert reset mid-BLINK -> outputs zero asynchronously. Undefined LIVES_HEART_BLINK_EN: miss -> heart_enable=3'b011 next cycle, blinking=0 throughout.
